// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: FSM states, access
// size codes and the size-to-byte-count mapping.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Code 2'b11 falls through to a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto a byte-wide synchronous RAM,
// sequencing little-endian byte cycles and assembling 32-bit read results.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ls_req_in,
    input  logic                  ls_wr_in,
    input  logic [1:0]            ls_size_in,
    input  logic [ADDR_WIDTH-1:0] ls_addr_in,
    input  logic [31:0]           ls_data_in,
    output logic                  ls_done_out,
    output logic [31:0]           ls_data_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    state_t                state, state_nxt;
    logic [2:0]            k, k_nxt;
    logic [2:0]            len, len_nxt;
    logic [ADDR_WIDTH-1:0] base, base_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [31:0]           wdata, wdata_nxt;
    logic [31:0]           rbuf, rbuf_nxt;
    logic [31:0]           if_data, if_data_nxt;
    logic [31:0]           ls_data, ls_data_nxt;
    logic [7:0]            dout, dout_nxt;
    logic                  wr, wr_nxt;
    logic                  if_done, if_done_nxt;
    logic                  ls_done, ls_done_nxt;
    logic                  rdy_q;
    logic [7:0]            hold, hold_nxt;
    logic                  hold_vld, hold_vld_nxt;

    logic [2:0]            k_inc;
    logic [1:0]            cap_idx;
    logic [7:0]            rd_byte;
    logic [31:0]           merged;
    logic                  ls_ok;
    logic                  if_ok;

    // In a read state, cycle k captures the byte addressed in cycle k-1.
    assign k_inc   = k + 3'd1;
    assign cap_idx = k[1:0] - 2'd1;
    assign rd_byte = hold_vld ? hold : mem_din;

    // A requester still holding req in its own done cycle must not restart.
    assign ls_ok = ls_req_in && !ls_done;
    assign if_ok = if_req_in && !if_done;

    always_comb begin
        merged = rbuf;
        merged[{cap_idx, 3'b000} +: 8] = rd_byte;
    end

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        len_nxt      = len;
        base_nxt     = base;
        addr_nxt     = addr;
        wdata_nxt    = wdata;
        rbuf_nxt     = rbuf;
        if_data_nxt  = if_data;
        ls_data_nxt  = ls_data;
        dout_nxt     = dout;
        wr_nxt       = wr;
        if_done_nxt  = if_done;
        ls_done_nxt  = ls_done;
        hold_nxt     = hold;
        hold_vld_nxt = hold_vld;

        if (!rdy_in) begin
            // The first stalled cycle still carries the byte addressed before
            // the stall; keep it, since the RAM moves on to the held mem_a.
            if (rdy_q) begin
                hold_nxt     = mem_din;
                hold_vld_nxt = 1'b1;
            end
        end else begin
            hold_vld_nxt = 1'b0;
            wr_nxt       = 1'b0;
            if_done_nxt  = 1'b0;
            ls_done_nxt  = 1'b0;
            case (state)
                IDLE: begin
                    if (!clear_in && ls_ok) begin
                        base_nxt  = ls_addr_in;
                        addr_nxt  = ls_addr_in;
                        len_nxt   = size_bytes(ls_size_in);
                        k_nxt     = 3'd0;
                        wdata_nxt = ls_data_in;
                        rbuf_nxt  = 32'h0;
                        if (ls_wr_in) begin
                            state_nxt = LS_WR;
                            dout_nxt  = ls_data_in[7:0];
                            wr_nxt    = 1'b1;
                        end else begin
                            state_nxt = LS_RD;
                        end
                    end else if (!clear_in && if_ok) begin
                        base_nxt  = if_addr_in;
                        addr_nxt  = if_addr_in;
                        len_nxt   = 3'd4;
                        k_nxt     = 3'd0;
                        rbuf_nxt  = 32'h0;
                        state_nxt = IF_RD;
                    end
                end
                IF_RD, LS_RD: begin
                    if (clear_in) begin
                        state_nxt = IDLE;
                    end else begin
                        if (k != 3'd0) begin
                            rbuf_nxt = merged;
                        end
                        if (k == len) begin
                            state_nxt = IDLE;
                            if (state == IF_RD) begin
                                if_data_nxt = merged;
                                if_done_nxt = 1'b1;
                            end else begin
                                ls_data_nxt = merged;
                                ls_done_nxt = 1'b1;
                            end
                        end else begin
                            k_nxt = k_inc;
                            if (k_inc < len) begin
                                addr_nxt = base + ADDR_WIDTH'(k_inc);
                            end
                        end
                    end
                end
                LS_WR: begin
                    // Stores ignore clear: a partially written word is never left behind.
                    if (k_inc < len) begin
                        k_nxt    = k_inc;
                        addr_nxt = base + ADDR_WIDTH'(k_inc);
                        dout_nxt = wdata[{k_inc[1:0], 3'b000} +: 8];
                        wr_nxt   = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        ls_done_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            k        <= 3'd0;
            len      <= 3'd0;
            base     <= '0;
            addr     <= '0;
            wdata    <= 32'h0;
            rbuf     <= 32'h0;
            if_data  <= 32'h0;
            ls_data  <= 32'h0;
            dout     <= 8'h0;
            wr       <= 1'b0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            rdy_q    <= 1'b0;
            hold     <= 8'h0;
            hold_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            len      <= len_nxt;
            base     <= base_nxt;
            addr     <= addr_nxt;
            wdata    <= wdata_nxt;
            rbuf     <= rbuf_nxt;
            if_data  <= if_data_nxt;
            ls_data  <= ls_data_nxt;
            dout     <= dout_nxt;
            wr       <= wr_nxt;
            if_done  <= if_done_nxt;
            ls_done  <= ls_done_nxt;
            rdy_q    <= rdy_in;
            hold     <= hold_nxt;
            hold_vld <= hold_vld_nxt;
        end
    end

    assign mem_a       = addr;
    assign mem_dout    = dout;
    assign mem_wr      = wr && rdy_in;
    assign if_done_out = if_done;
    assign if_data_out = if_data;
    assign ls_done_out = ls_done;
    assign ls_data_out = ls_data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed transfers against a behavioural
// byte RAM; a negedge monitor checks done pulses, write cycles and addresses.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = 32'h0;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        ls_req_in = 1'b0;
    logic        ls_wr_in = 1'b0;
    logic [1:0]  ls_size_in = 2'b00;
    logic [31:0] ls_addr_in = 32'h0;
    logic [31:0] ls_data_in = 32'h0;
    logic        ls_done_out;
    logic [31:0] ls_data_out;
    logic [7:0]  mem_din = 8'h0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_req_in(ls_req_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
        .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
        .ls_done_out(ls_done_out), .ls_data_out(ls_data_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Behavioural RAM: fixed initial image, overlaid by written bytes.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1001: return 8'h05;
            32'h0000_2000: return 8'h11;
            32'h0000_2001: return 8'h22;
            32'h0000_2002: return 8'h33;
            32'h0000_2003: return 8'h44;
            32'hFFFF_FFFF: return 8'h5A;
            32'h0000_0000: return 8'hC3;
            default:       return 8'h00;
        endcase
    endfunction

    always @(posedge clk_in) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } byte_t;

    done_t if_q[$];
    done_t ls_q[$];
    byte_t wr_q[$];
    byte_t rd_q[$];

    int tests = 0;
    int fails = 0;
    int t;
    logic [7:0] be_bytes [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk_in) begin : monitor
        done_t d;
        byte_t b;
        if (if_done_out === 1'b1) begin
            if (if_q.size() == 0) begin
                chk("if_done unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                d = if_q.pop_front();
                chk("if_done cycle", 32'(cyc), 32'(d.cyc));
                if (d.chk) chk("if_data", if_data_out, d.data);
            end
        end
        if (ls_done_out === 1'b1) begin
            if (ls_q.size() == 0) begin
                chk("ls_done unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                d = ls_q.pop_front();
                chk("ls_done cycle", 32'(cyc), 32'(d.cyc));
                if (d.chk) chk("ls_data", ls_data_out, d.data);
            end
        end
        if (mem_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("mem_wr unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                b = wr_q.pop_front();
                chk("wr cycle", 32'(cyc), 32'(b.cyc));
                chk("wr addr", mem_a, b.addr);
                chk("wr byte", {24'h0, mem_dout}, {24'h0, b.data});
            end
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            b = rd_q.pop_front();
            chk("rd mem_a", mem_a, b.addr);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, " mem_a"}, mem_a, 32'h0);
        chk({tag, " mem_wr"}, {31'h0, mem_wr}, 32'h0);
        chk({tag, " mem_dout"}, {24'h0, mem_dout}, 32'h0);
        chk({tag, " if_done"}, {31'h0, if_done_out}, 32'h0);
        chk({tag, " ls_done"}, {31'h0, ls_done_out}, 32'h0);
        chk({tag, " if_data"}, if_data_out, 32'h0);
        chk({tag, " ls_data"}, ls_data_out, 32'h0);
    endtask

    task automatic start_ls(input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        ls_wr_in   = wr;
        ls_size_in = sz;
        ls_addr_in = a;
        ls_data_in = d;
        ls_req_in  = 1'b1;
    endtask

    task automatic wait_ls();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_in);
            seen = (ls_done_out === 1'b1);
        end
        if (!seen) chk("ls_done timeout", 32'h0, 32'h1);
        @(posedge clk_in); #1;
        ls_req_in = 1'b0;
    endtask

    task automatic wait_if();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_in);
            seen = (if_done_out === 1'b1);
        end
        if (!seen) chk("if_done timeout", 32'h0, 32'h1);
        @(posedge clk_in); #1;
        if_req_in = 1'b0;
    endtask

    // Load of n bytes from a; result and done latency are hand-computed.
    task automatic run_load(input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] exp, input int n, input int lat);
        int t0;
        @(posedge clk_in); #1;
        t0 = cyc;
        for (int i = 0; i < n; i++)
            rd_q.push_back('{addr: a + 32'(i), data: 8'h00, cyc: t0 + 1 + i});
        ls_q.push_back('{data: exp, cyc: t0 + lat, chk: 1'b1});
        start_ls(1'b0, sz, a, 32'h0);
        wait_ls();
    endtask

    task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp);
        int t0;
        @(posedge clk_in); #1;
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            rd_q.push_back('{addr: a + 32'(i), data: 8'h00, cyc: t0 + 1 + i});
        if_q.push_back('{data: exp, cyc: t0 + 6, chk: 1'b1});
        if_addr_in = a;
        if_req_in  = 1'b1;
        wait_if();
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_zero("reset");
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        run_fetch(32'h0000_1000, 32'h0000_0513);

        // Store and fetch requested together: store wins, fetch follows at t+5.
        @(posedge clk_in); #1;
        t = cyc;
        for (int i = 0; i < 4; i++)
            wr_q.push_back('{addr: 32'h20 + 32'(i), data: be_bytes[i], cyc: t + 1 + i});
        ls_q.push_back('{data: 32'h0, cyc: t + 5, chk: 1'b0});
        for (int i = 0; i < 4; i++)
            rd_q.push_back('{addr: 32'h1000 + 32'(i), data: 8'h00, cyc: t + 6 + i});
        if_q.push_back('{data: 32'h0000_0513, cyc: t + 11, chk: 1'b1});
        start_ls(1'b1, SIZE_W, 32'h20, 32'hDEAD_BEEF);
        if_addr_in = 32'h1000;
        if_req_in  = 1'b1;
        fork
            wait_ls();
            wait_if();
        join

        run_load(SIZE_W, 32'h20, 32'hDEAD_BEEF, 4, 6);
        run_load(SIZE_H, 32'hFFFF_FFFF, 32'h0000_C35A, 2, 4);
        run_load(2'b11, 32'h2000, 32'h4433_2211, 4, 6);

        // Clear during fetch byte 2, then a byte load accepted the very next cycle.
        @(posedge clk_in); #1;
        t = cyc;
        for (int i = 0; i < 3; i++)
            rd_q.push_back('{addr: 32'h2000 + 32'(i), data: 8'h00, cyc: t + 1 + i});
        if_addr_in = 32'h2000;
        if_req_in  = 1'b1;
        repeat (3) begin @(posedge clk_in); #1; end
        clear_in = 1'b1;
        @(posedge clk_in); #1;
        clear_in  = 1'b0;
        if_req_in = 1'b0;
        t = cyc;
        rd_q.push_back('{addr: 32'h2002, data: 8'h00, cyc: t + 1});
        ls_q.push_back('{data: 32'h0000_0033, cyc: t + 3, chk: 1'b1});
        start_ls(1'b0, SIZE_B, 32'h2002, 32'h0);
        wait_ls();

        // Byte store with clear asserted mid-transfer still completes.
        @(posedge clk_in); #1;
        t = cyc;
        wr_q.push_back('{addr: 32'h60, data: 8'hA7, cyc: t + 1});
        ls_q.push_back('{data: 32'h0, cyc: t + 2, chk: 1'b0});
        start_ls(1'b1, SIZE_B, 32'h60, 32'h1234_56A7);
        @(posedge clk_in); #1;
        clear_in = 1'b1;
        @(posedge clk_in); #1;
        clear_in = 1'b0;
        wait_ls();

        // Three-cycle stall in the middle of a word load.
        @(posedge clk_in); #1;
        t = cyc;
        rd_q.push_back('{addr: 32'h2000, data: 8'h00, cyc: t + 1});
        rd_q.push_back('{addr: 32'h2001, data: 8'h00, cyc: t + 2});
        for (int i = 3; i <= 6; i++)
            rd_q.push_back('{addr: 32'h2002, data: 8'h00, cyc: t + i});
        rd_q.push_back('{addr: 32'h2003, data: 8'h00, cyc: t + 7});
        ls_q.push_back('{data: 32'h4433_2211, cyc: t + 9, chk: 1'b1});
        start_ls(1'b0, SIZE_W, 32'h2000, 32'h0);
        repeat (3) begin @(posedge clk_in); #1; end
        rdy_in = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        rdy_in = 1'b1;
        wait_ls();

        // Two-cycle stall between the bytes of a half store; no write while stalled.
        @(posedge clk_in); #1;
        t = cyc;
        wr_q.push_back('{addr: 32'h40, data: 8'h88, cyc: t + 1});
        wr_q.push_back('{addr: 32'h41, data: 8'h77, cyc: t + 4});
        ls_q.push_back('{data: 32'h0, cyc: t + 5, chk: 1'b0});
        start_ls(1'b1, SIZE_H, 32'h40, 32'h0000_7788);
        repeat (2) begin @(posedge clk_in); #1; end
        rdy_in = 1'b0;
        repeat (2) begin @(posedge clk_in); #1; end
        rdy_in = 1'b1;
        wait_ls();
        run_load(SIZE_H, 32'h40, 32'h0000_7788, 2, 4);

        // Reset while the second byte of a word store is on the bus.
        @(posedge clk_in); #1;
        t = cyc;
        wr_q.push_back('{addr: 32'h50, data: 8'h44, cyc: t + 1});
        wr_q.push_back('{addr: 32'h51, data: 8'h33, cyc: t + 2});
        start_ls(1'b1, SIZE_W, 32'h50, 32'h1122_3344);
        repeat (2) begin @(posedge clk_in); #1; end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in    = 1'b0;
        ls_req_in = 1'b0;
        @(negedge clk_in);
        check_zero("mid-store reset");
        repeat (4) @(posedge clk_in);
        run_load(SIZE_W, 32'h50, 32'h0000_3344, 4, 6);

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("if_q leftover", 32'(if_q.size()), 32'h0);
        chk("ls_q leftover", 32'(ls_q.size()), 32'h0);
        chk("wr_q leftover", 32'(wr_q.size()), 32'h0);
        chk("rd_q leftover", 32'(rd_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
